// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Inserts a bubble on flush or hazard and counts hazard bubbles.
module id_ex_stage #(
  parameter int NB_DATA    = 32,
  parameter int NB_REG     = 5,
  parameter int NB_CTRL_WB = 2,
  parameter int NB_CTRL_M  = 3,
  parameter int NB_CTRL_EX = 3,
  parameter int NB_CNT     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_flush,
  input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
  input  logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus,
  input  logic [NB_CTRL_EX-1:0] i_ctrl_exc_bus,
  input  logic [NB_DATA-1:0]    i_pc_plus4,
  input  logic [NB_DATA-1:0]    i_read_data1,
  input  logic [NB_DATA-1:0]    i_read_data2,
  input  logic [NB_DATA-1:0]    i_imm_ext,
  input  logic [NB_REG-1:0]     i_rs,
  input  logic [NB_REG-1:0]     i_rt,
  input  logic [NB_REG-1:0]     i_rd,
  output logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus,
  output logic [NB_CTRL_M-1:0]  o_ctrl_mem_bus,
  output logic [NB_CTRL_EX-1:0] o_ctrl_exc_bus,
  output logic [NB_DATA-1:0]    o_pc_plus4,
  output logic [NB_DATA-1:0]    o_read_data1,
  output logic [NB_DATA-1:0]    o_read_data2,
  output logic [NB_DATA-1:0]    o_imm_ext,
  output logic [NB_REG-1:0]     o_rs,
  output logic [NB_REG-1:0]     o_rt,
  output logic [NB_REG-1:0]     o_rd,
  output logic                  o_stall,
  output logic [NB_CNT-1:0]     o_stall_count
);

  logic [NB_CTRL_WB-1:0] ctrl_wb_q, ctrl_wb_d;
  logic [NB_CTRL_M-1:0]  ctrl_mem_q, ctrl_mem_d;
  logic [NB_CTRL_EX-1:0] ctrl_exc_q, ctrl_exc_d;
  logic [NB_DATA-1:0]    pc_plus4_q, pc_plus4_d;
  logic [NB_DATA-1:0]    read_data1_q, read_data1_d;
  logic [NB_DATA-1:0]    read_data2_q, read_data2_d;
  logic [NB_DATA-1:0]    imm_ext_q, imm_ext_d;
  logic [NB_REG-1:0]     rs_q, rs_d;
  logic [NB_REG-1:0]     rt_q, rt_d;
  logic [NB_REG-1:0]     rd_q, rd_d;
  logic [NB_CNT-1:0]     stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic rt_match;
  logic bubble;
  logic cnt_full;

  // A load in EX whose target feeds the instruction now in ID.
  assign rt_match = (rt_q == i_rs) || (rt_q == i_rt);
  assign load_use = ctrl_mem_q[1]
                  && (rt_q != '0)
                  && rt_match;

  assign bubble   = i_flush || load_use;
  assign cnt_full = &stall_cnt_q;

  always_comb begin
    ctrl_wb_d    = ctrl_wb_q;
    ctrl_mem_d   = ctrl_mem_q;
    ctrl_exc_d   = ctrl_exc_q;
    pc_plus4_d   = pc_plus4_q;
    read_data1_d = read_data1_q;
    read_data2_d = read_data2_q;
    imm_ext_d    = imm_ext_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    stall_cnt_d  = stall_cnt_q;
    if (i_enable) begin
      pc_plus4_d   = i_pc_plus4;
      read_data1_d = i_read_data1;
      read_data2_d = i_read_data2;
      imm_ext_d    = i_imm_ext;
      rs_d         = i_rs;
      rt_d         = i_rt;
      rd_d         = i_rd;
      if (bubble) begin
        ctrl_wb_d  = '0;
        ctrl_mem_d = '0;
        ctrl_exc_d = '0;
      end else begin
        ctrl_wb_d  = i_ctrl_wb_bus;
        ctrl_mem_d = i_ctrl_mem_bus;
        ctrl_exc_d = i_ctrl_exc_bus;
      end
      // Flush wins over a simultaneous hazard and is not counted.
      if (!i_flush && load_use && !cnt_full) begin
        stall_cnt_d = stall_cnt_q + NB_CNT'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      ctrl_wb_q    <= '0;
      ctrl_mem_q   <= '0;
      ctrl_exc_q   <= '0;
      pc_plus4_q   <= '0;
      read_data1_q <= '0;
      read_data2_q <= '0;
      imm_ext_q    <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      stall_cnt_q  <= '0;
    end else begin
      ctrl_wb_q    <= ctrl_wb_d;
      ctrl_mem_q   <= ctrl_mem_d;
      ctrl_exc_q   <= ctrl_exc_d;
      pc_plus4_q   <= pc_plus4_d;
      read_data1_q <= read_data1_d;
      read_data2_q <= read_data2_d;
      imm_ext_q    <= imm_ext_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign o_ctrl_wb_bus  = ctrl_wb_q;
  assign o_ctrl_mem_bus = ctrl_mem_q;
  assign o_ctrl_exc_bus = ctrl_exc_q;
  assign o_pc_plus4     = pc_plus4_q;
  assign o_read_data1   = read_data1_q;
  assign o_read_data2   = read_data2_q;
  assign o_imm_ext      = imm_ext_q;
  assign o_rs           = rs_q;
  assign o_rt           = rt_q;
  assign o_rd           = rd_q;
  assign o_stall        = load_use;
  assign o_stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random
// stimulus against a behavioural pipeline-register model.
module tb_id_ex_stage;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int VW    = 2 + 3 + 3 + 4 * 32 + 3 * 5 + CNT_W;

  logic clk;
  logic i_rst, i_enable, i_flush;
  logic [1:0]  in_wb;
  logic [2:0]  in_mem, in_ex;
  logic [31:0] in_pc, in_d1, in_d2, in_imm;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [1:0]  o_wb;
  logic [2:0]  o_mem, o_ex;
  logic [31:0] o_pc, o_d1, o_d2, o_imm;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic        o_stall;
  logic [CNT_W-1:0] o_cnt;

  logic [1:0]  m_wb;
  logic [2:0]  m_mem, m_ex;
  logic [31:0] m_pc, m_d1, m_d2, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd;
  int          m_cnt;

  int n_pass  = 0;
  int n_total = 0;

  id_ex_stage #(.NB_CNT(CNT_W)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_enable(i_enable),
    .i_flush(i_flush),
    .i_ctrl_wb_bus(in_wb), .i_ctrl_mem_bus(in_mem),
    .i_ctrl_exc_bus(in_ex),
    .i_pc_plus4(in_pc), .i_read_data1(in_d1),
    .i_read_data2(in_d2), .i_imm_ext(in_imm),
    .i_rs(in_rs), .i_rt(in_rt), .i_rd(in_rd),
    .o_ctrl_wb_bus(o_wb), .o_ctrl_mem_bus(o_mem),
    .o_ctrl_exc_bus(o_ex),
    .o_pc_plus4(o_pc), .o_read_data1(o_d1),
    .o_read_data2(o_d2), .o_imm_ext(o_imm),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
    .o_stall(o_stall), .o_stall_count(o_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [VW-1:0] dut_vec();
    return {o_wb, o_mem, o_ex, o_pc, o_d1, o_d2, o_imm,
            o_rs, o_rt, o_rd, o_cnt};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    return {m_wb, m_mem, m_ex, m_pc, m_d1, m_d2, m_imm,
            m_rs, m_rt, m_rd, CNT_W'(m_cnt)};
  endfunction

  // A load sits in EX and its destination is read by ID.
  function automatic logic ref_stall();
    return m_mem[1] && (m_rt != 0)
        && (m_rt == in_rs || m_rt == in_rt);
  endfunction

  task automatic set_instr(input logic [1:0] wb,
                           input logic [2:0] mem,
                           input logic [2:0] ex,
                           input logic [4:0] rs,
                           input logic [4:0] rt,
                           input logic [4:0] rd);
    in_wb = wb; in_mem = mem; in_ex = ex;
    in_rs = rs; in_rt = rt; in_rd = rd;
    in_pc  = $urandom; in_d1 = $urandom;
    in_d2  = $urandom; in_imm = $urandom;
  endtask

  task automatic rand_inputs();
    in_wb  = 2'($urandom); in_mem = 3'($urandom);
    in_ex  = 3'($urandom);
    in_pc  = $urandom; in_d1 = $urandom;
    in_d2  = $urandom; in_imm = $urandom;
    in_rs  = 5'($urandom_range(0, 3));
    in_rt  = 5'($urandom_range(0, 3));
    in_rd  = 5'($urandom);
  endtask

  // One clock edge; the model follows the register rules.
  task automatic tick(input logic rst, input logic en,
                      input logic fl);
    logic hz;
    i_rst = rst; i_enable = en; i_flush = fl;
    hz = ref_stall();
    @(posedge clk);
    if (!rst) begin
      {m_wb, m_mem, m_ex} = '0;
      {m_pc, m_d1, m_d2, m_imm} = '0;
      {m_rs, m_rt, m_rd} = '0;
      m_cnt = 0;
    end else if (en) begin
      m_pc = in_pc; m_d1 = in_d1; m_d2 = in_d2;
      m_imm = in_imm;
      m_rs = in_rs; m_rt = in_rt; m_rd = in_rd;
      if (fl || hz) begin
        m_wb = '0; m_mem = '0; m_ex = '0;
      end else begin
        m_wb = in_wb; m_mem = in_mem; m_ex = in_ex;
      end
      if (!fl && hz && m_cnt < CMAX) m_cnt++;
    end
    #1;
  endtask

  task automatic test_reset();
    {in_wb, in_mem, in_ex} = '1;
    {in_pc, in_d1, in_d2, in_imm} = '1;
    {in_rs, in_rt, in_rd} = '1;
    tick(1'b0, 1'b1, 1'b1);
    n_total++;
    if (dut_vec() !== '0)
      $display("FAIL reset_regs got=%h exp=0", dut_vec());
    else n_pass++;
    n_total++;
    if (o_stall !== 1'b0)
      $display("FAIL reset_stall got=%b exp=0", o_stall);
    else n_pass++;
  endtask

  task automatic test_pass_through();
    logic [VW-1:0] exp;
    tick(1'b0, 1'b1, 1'b0);
    set_instr(2'b10, 3'b000, 3'b100, 5'd1, 5'd2, 5'd3);
    in_d1 = 32'h11;
    tick(1'b1, 1'b1, 1'b0);
    exp = {2'b10, 3'b000, 3'b100, in_pc, 32'h11, in_d2,
           in_imm, 5'd1, 5'd2, 5'd3, CNT_W'(0)};
    n_total++;
    if (dut_vec() !== exp)
      $display("FAIL pass_through got=%h exp=%h",
               dut_vec(), exp);
    else n_pass++;
    n_total++;
    if (o_stall !== 1'b0)
      $display("FAIL pass_stall got=%b exp=0", o_stall);
    else n_pass++;
  endtask

  task automatic test_load_use();
    tick(1'b0, 1'b1, 1'b0);
    set_instr(2'b11, 3'b010, 3'b001, 5'd1, 5'd5, 5'd0);
    tick(1'b1, 1'b1, 1'b0);
    set_instr(2'b10, 3'b000, 3'b100, 5'd5, 5'd6, 5'd7);
    #1;
    n_total++;
    if (o_stall !== 1'b1)
      $display("FAIL lu_stall got=%b exp=1", o_stall);
    else n_pass++;
    tick(1'b1, 1'b1, 1'b0);
    n_total++;
    if ({o_wb, o_mem, o_ex, o_cnt} !== {8'h00, CNT_W'(1)})
      $display("FAIL lu_bubble got=%h exp=%h",
               {o_wb, o_mem, o_ex, o_cnt}, {8'h00, CNT_W'(1)});
    else n_pass++;
    n_total++;
    if (o_stall !== 1'b0)
      $display("FAIL lu_clear got=%b exp=0", o_stall);
    else n_pass++;
    tick(1'b1, 1'b1, 1'b0);
    n_total++;
    if ({o_wb, o_mem, o_ex, o_rs} !== {8'b10_000_100, 5'd5})
      $display("FAIL lu_reload got=%h exp=%h",
               {o_wb, o_mem, o_ex, o_rs}, {8'b10_000_100, 5'd5});
    else n_pass++;
    n_total++;
    if (dut_vec() !== model_vec())
      $display("FAIL lu_model got=%h exp=%h",
               dut_vec(), model_vec());
    else n_pass++;
  endtask

  task automatic test_zero_reg();
    int c0;
    set_instr(2'b11, 3'b010, 3'b001, 5'd2, 5'd0, 5'd0);
    tick(1'b1, 1'b1, 1'b0);
    c0 = m_cnt;
    set_instr(2'b10, 3'b000, 3'b100, 5'd0, 5'd0, 5'd4);
    #1;
    n_total++;
    if (o_stall !== 1'b0)
      $display("FAIL zero_stall got=%b exp=0", o_stall);
    else n_pass++;
    tick(1'b1, 1'b1, 1'b0);
    n_total++;
    if ({o_wb, o_mem, o_ex, o_cnt} !==
        {8'b10_000_100, CNT_W'(c0)})
      $display("FAIL zero_nobubble got=%h exp=%h",
               {o_wb, o_mem, o_ex, o_cnt},
               {8'b10_000_100, CNT_W'(c0)});
    else n_pass++;
  endtask

  task automatic test_flush_priority();
    int c0;
    set_instr(2'b11, 3'b010, 3'b001, 5'd1, 5'd5, 5'd0);
    tick(1'b1, 1'b1, 1'b0);
    c0 = m_cnt;
    set_instr(2'b10, 3'b100, 3'b111, 5'd5, 5'd5, 5'd9);
    #1;
    n_total++;
    if (o_stall !== 1'b1)
      $display("FAIL flush_hz got=%b exp=1", o_stall);
    else n_pass++;
    tick(1'b1, 1'b1, 1'b1);
    n_total++;
    if ({o_wb, o_mem, o_ex, o_cnt} !== {8'h00, CNT_W'(c0)})
      $display("FAIL flush_prio got=%h exp=%h",
               {o_wb, o_mem, o_ex, o_cnt}, {8'h00, CNT_W'(c0)});
    else n_pass++;
  endtask

  task automatic test_enable_hold();
    logic [VW-1:0] snap;
    set_instr(2'b11, 3'b010, 3'b011, 5'd3, 5'd4, 5'd5);
    tick(1'b1, 1'b1, 1'b0);
    snap = dut_vec();
    for (int k = 0; k < 3; k++) begin
      rand_inputs();
      in_rs = 5'd4;
      tick(1'b1, 1'b0, k[0]);
      n_total++;
      if (dut_vec() !== model_vec())
        $display("FAIL hold_%0d got=%h exp=%h",
                 k, dut_vec(), model_vec());
      else n_pass++;
    end
    n_total++;
    if (o_stall !== 1'b1)
      $display("FAIL hold_stall got=%b exp=1", o_stall);
    else n_pass++;
    tick(1'b1, 1'b1, 1'b0);
    n_total++;
    if (dut_vec() !== model_vec() || dut_vec() === snap)
      $display("FAIL hold_resume got=%h exp=%h",
               dut_vec(), model_vec());
    else n_pass++;
  endtask

  task automatic test_saturation();
    tick(1'b0, 1'b1, 1'b0);
    set_instr(2'b11, 3'b010, 3'b001, 5'd5, 5'd5, 5'd0);
    for (int k = 0; k < 2 * CMAX + 8; k++)
      tick(1'b1, 1'b1, 1'b0);
    n_total++;
    if (o_cnt !== CNT_W'(CMAX))
      $display("FAIL sat_count got=%0d exp=%0d", o_cnt, CMAX);
    else n_pass++;
    n_total++;
    if (dut_vec() !== model_vec())
      $display("FAIL sat_model got=%h exp=%h",
               dut_vec(), model_vec());
    else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    tick(1'b0, 1'b1, 1'b0);
    set_instr(2'b11, 3'b010, 3'b001, 5'd5, 5'd5, 5'd0);
    tick(1'b1, 1'b1, 1'b0);
    n_total++;
    if (o_stall !== 1'b1)
      $display("FAIL rms_pre got=%b exp=1", o_stall);
    else n_pass++;
    tick(1'b0, 1'b1, 1'b0);
    n_total++;
    if (dut_vec() !== '0 || o_stall !== 1'b0)
      $display("FAIL rms_clear got=%h/%b exp=0/0",
               dut_vec(), o_stall);
    else n_pass++;
    tick(1'b1, 1'b1, 1'b0);
    n_total++;
    if ({o_wb, o_mem, o_ex} !== 8'b11_010_001)
      $display("FAIL rms_first got=%h exp=%h",
               {o_wb, o_mem, o_ex}, 8'b11_010_001);
    else n_pass++;
  endtask

  task automatic test_random();
    logic en, fl, rst;
    tick(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 400; k++) begin
      rand_inputs();
      if ($urandom_range(0, 3) == 0) in_mem[1] = 1'b1;
      en  = ($urandom_range(0, 7) != 0);
      fl  = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 49) != 0);
      #1;
      n_total++;
      if (o_stall !== ref_stall())
        $display("FAIL rnd_stall_%0d got=%b exp=%b",
                 k, o_stall, ref_stall());
      else n_pass++;
      tick(rst, en, fl);
      n_total++;
      if (dut_vec() !== model_vec())
        $display("FAIL rnd_regs_%0d got=%h exp=%h",
                 k, dut_vec(), model_vec());
      else n_pass++;
    end
  endtask

  initial begin
    i_rst = 1'b0; i_enable = 1'b0; i_flush = 1'b0;
    rand_inputs();
    test_reset();
    test_pass_through();
    test_load_use();
    test_zero_reg();
    test_flush_priority();
    test_enable_hold();
    test_saturation();
    test_reset_mid_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
